// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF/ID and ID/EX registers, control decode, load-use bubbles,
// EX back-pressure and redirect flush. Define ID_ILLEGAL_DET_EN to flag unknown opcodes.
module id_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             ex_stall,
  input  logic             ex_redirect,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic             ex_alu_src_imm,
  output logic             illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             r_id_valid;
  logic [31:0]      r_id_instr;
  logic [31:0]      r_id_pc;
  logic             r_ex_valid;
  logic [31:0]      r_ex_instr;
  logic [31:0]      r_ex_pc;
  logic [4:0]       r_ex_rd;
  logic [4:0]       r_ex_rs1;
  logic [4:0]       r_ex_rs2;
  logic             r_ex_reg_write;
  logic             r_ex_mem_read;
  logic             r_ex_mem_write;
  logic             r_ex_branch;
  logic             r_ex_jump;
  logic             r_ex_alu_src_imm;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic       w_rw, w_mr, w_mw, w_br, w_jp, w_imm, w_legal;
  logic       w_uses_rs1, w_uses_rs2;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic       w_load_use, w_ex_load, w_ex_clear;

  assign w_rd  = r_id_instr[11:7];
  assign w_rs1 = r_id_instr[19:15];
  assign w_rs2 = r_id_instr[24:20];

  always_comb begin
    w_rw       = 1'b0;
    w_mr       = 1'b0;
    w_mw       = 1'b0;
    w_br       = 1'b0;
    w_jp       = 1'b0;
    w_imm      = 1'b0;
    w_legal    = 1'b1;
    w_uses_rs1 = 1'b1;
    w_uses_rs2 = 1'b0;
    case (r_id_instr[6:0])
      7'b0110011: begin w_rw = 1'b1; w_uses_rs2 = 1'b1; end
      7'b0010011: begin w_rw = 1'b1; w_imm = 1'b1; end
      7'b0000011: begin w_rw = 1'b1; w_mr = 1'b1; w_imm = 1'b1; end
      7'b0100011: begin w_mw = 1'b1; w_imm = 1'b1; w_uses_rs2 = 1'b1; end
      7'b1100011: begin w_br = 1'b1; w_uses_rs2 = 1'b1; end
      7'b1101111: begin w_rw = 1'b1; w_jp = 1'b1; w_uses_rs1 = 1'b0; end
      7'b1100111: begin w_rw = 1'b1; w_jp = 1'b1; w_imm = 1'b1; end
      7'b0110111,
      7'b0010111: begin w_rw = 1'b1; w_imm = 1'b1; w_uses_rs1 = 1'b0; end
      default:    w_legal = 1'b0;
    endcase
  end

  // r_ex_rd is already zero for non-writing instructions, so a nonzero match implies a real RAW.
  assign w_load_use = r_id_valid & r_ex_valid & r_ex_mem_read & (r_ex_rd != 5'd0) &
                      ((w_uses_rs1 & (w_rs1 == r_ex_rd)) | (w_uses_rs2 & (w_rs2 == r_ex_rd)));

  // Fetch handshake: a word transfers on a rising edge where if_valid & if_ready are both 1;
  // if_ready depends only on this cycle's redirect/stall/hazard terms, never on if_valid.
  // During a redirect if_ready is 1 but the presented word is dropped by the flush.
  assign if_ready   = ~rst & (ex_redirect | (~ex_stall & ~w_load_use));
  assign w_ex_load  = ~ex_redirect & ~ex_stall & ~w_load_use;
  assign w_ex_clear = ex_redirect | (~ex_stall & w_load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_valid       <= 1'b0;
      r_id_instr       <= 32'd0;
      r_id_pc          <= 32'd0;
      r_ex_valid       <= 1'b0;
      r_ex_instr       <= 32'd0;
      r_ex_pc          <= 32'd0;
      r_ex_rd          <= 5'd0;
      r_ex_rs1         <= 5'd0;
      r_ex_rs2         <= 5'd0;
      r_ex_reg_write   <= 1'b0;
      r_ex_mem_read    <= 1'b0;
      r_ex_mem_write   <= 1'b0;
      r_ex_branch      <= 1'b0;
      r_ex_jump        <= 1'b0;
      r_ex_alu_src_imm <= 1'b0;
      r_bubble_cnt     <= '0;
    end else begin
      if (ex_redirect) begin
        r_id_valid <= 1'b0;
      end else if (w_ex_load) begin
        r_id_valid <= if_valid;
        r_id_instr <= if_instr;
        r_id_pc    <= if_pc;
      end
      if (w_ex_clear) begin
        r_ex_valid       <= 1'b0;
        r_ex_rd          <= 5'd0;
        r_ex_rs1         <= 5'd0;
        r_ex_rs2         <= 5'd0;
        r_ex_reg_write   <= 1'b0;
        r_ex_mem_read    <= 1'b0;
        r_ex_mem_write   <= 1'b0;
        r_ex_branch      <= 1'b0;
        r_ex_jump        <= 1'b0;
        r_ex_alu_src_imm <= 1'b0;
      end else if (w_ex_load) begin
        r_ex_valid       <= r_id_valid;
        r_ex_instr       <= r_id_instr;
        r_ex_pc          <= r_id_pc;
        r_ex_rd          <= (r_id_valid & w_rw) ? w_rd : 5'd0;
        r_ex_rs1         <= r_id_valid ? w_rs1 : 5'd0;
        r_ex_rs2         <= r_id_valid ? w_rs2 : 5'd0;
        r_ex_reg_write   <= r_id_valid & w_rw;
        r_ex_mem_read    <= r_id_valid & w_mr;
        r_ex_mem_write   <= r_id_valid & w_mw;
        r_ex_branch      <= r_id_valid & w_br;
        r_ex_jump        <= r_id_valid & w_jp;
        r_ex_alu_src_imm <= r_id_valid & w_imm;
      end
      if (~ex_redirect & ~ex_stall & w_load_use & ~(&r_bubble_cnt))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

`ifdef ID_ILLEGAL_DET_EN
  logic r_ex_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ex_illegal <= 1'b0;
    else if (w_ex_clear)
      r_ex_illegal <= 1'b0;
    else if (w_ex_load)
      r_ex_illegal <= r_id_valid & ~w_legal;
  end

  assign illegal = r_ex_valid & r_ex_illegal;
`else
  logic w_unused_legal;
  assign w_unused_legal = w_legal;
  assign illegal        = 1'b0;
`endif

  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;
  assign ex_valid       = r_ex_valid;
  assign ex_instr       = r_ex_instr;
  assign ex_pc          = r_ex_pc;
  assign ex_rd          = r_ex_rd;
  assign ex_rs1         = r_ex_rs1;
  assign ex_rs2         = r_ex_rs2;
  assign ex_reg_write   = r_ex_reg_write;
  assign ex_mem_read    = r_ex_mem_read;
  assign ex_mem_write   = r_ex_mem_write;
  assign ex_branch      = r_ex_branch;
  assign ex_jump        = r_ex_jump;
  assign ex_alu_src_imm = r_ex_alu_src_imm;
  assign bubble_cnt     = r_bubble_cnt;

endmodule
